qpu_exu_alu_arb: RTL and testbench
==================================

// Module: qpu_exu_alu_arb
// PURPOSE
//  Requestor-side front end of the shared EXU ALU datapath. Takes valid/ready
//  requests from ALU, BJP, LSU and QIU, grants one per cycle, and drives the
//  one-hot *_req_alu select, operands and op flags into the datapath.
//  Captures the combinational datapath result into a one-entry response
//  register returned with valid/ready, source ID and tag. Sits between the
//  EXU dispatch units and the ALU datapath.
// PARAMETERS
//  XLEN   32  operand/result width (equals QPU_XLEN)
//  TAG_W  4   requestor tag width, returned unchanged with the response
// PORTS
//  clk           in   1         clock
//  rst_n         in   1         synchronous active-low reset
//  req_valid     in   4         per-source request valid [0]=ALU [1]=BJP [2]=LSU [3]=QIU
//  req_ready     out  4         per-source accept; at most one bit set per cycle
//  req_op1       in   4*XLEN    operand 1, source i in [i*XLEN +: XLEN]
//  req_op2       in   4*XLEN    operand 2, same packing
//  req_tag       in   4*TAG_W   tag, same packing
//  alu_opsel     in   4         ALU op {add,or,xor,and}, must be one-hot
//  bjp_cmpsel    in   4         BJP compare {eq,ne,lt,gt}, must be one-hot
//  dp_req        out  4         one-hot {qiu,lsu,bjp,alu}_req_alu to datapath
//  dp_op1        out  XLEN      granted operand 1 (0 when no grant)
//  dp_op2        out  XLEN      granted operand 2 (0 when no grant)
//  dp_alu_op     out  4         alu_opsel passthrough when ALU granted, else 0
//  dp_bjp_cmp    out  4         bjp_cmpsel passthrough when BJP granted, else 0
//  dp_res        in   XLEN      datapath result (alu/lsu/qiu)
//  dp_cmp_res    in   1         datapath compare result (bjp)
//  rsp_valid     out  1         response valid
//  rsp_ready     in   1         response consumer ready
//  rsp_src       out  2         source index of response
//  rsp_tag       out  TAG_W     tag of response
//  rsp_res       out  XLEN      registered dp_res (0 for BJP)
//  rsp_cmp       out  1         registered dp_cmp_res (0 for non-BJP)
//  err_sticky    out  1         sticky illegal-op flag
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge): rsp_valid=0, rsp_src=0, rsp_tag=0, rsp_res=0,
//    rsp_cmp=0, err_sticky=0, RR pointer=3 (so ALU is next priority), state EMPTY.
//    Reset mid-transaction discards the held response; no replay.
//  - States: EMPTY (rsp_valid=0), FULL (rsp_valid=1).
//  - can_accept = EMPTY | (FULL & rsp_ready). Grant only when can_accept and
//    any req_valid; req_ready/dp_req = grant vector, else all 0.
//  - Handshake completes when req_valid[i]&req_ready[i]; the datapath is
//    combinational, so result is sampled at that same edge: latency 1 cycle
//    from accept to rsp_valid.
//  - EMPTY->FULL on accept; FULL->EMPTY on rsp_ready with no accept;
//    FULL->FULL on rsp_ready with accept (back-to-back, full throughput);
//    FULL & !rsp_ready: hold all rsp_* stable, req_ready=0.
//  - rsp_* only change on accept; requestor must hold op/tag while valid & !ready.
//  - err_sticky set on accepted ALU grant with alu_opsel not one-hot (0 or >1
//    bits), or accepted BJP grant with bjp_cmpsel not one-hot. Op still
//    forwarded as-is; response still returned. Cleared only by reset.
//  - LSU/QIU: dp_alu_op=0, dp_bjp_cmp=0; datapath performs add internally.
//  - No arithmetic here; widths pass through unmodified.
// CONFIGURATION
//  QPU_ALU_ARB_RR_EN defined: round-robin; search starts at (ptr+1) mod 4,
//    ptr <= granted index on each accept, wraps 3->0; unchanged when no accept.
//  Not defined: fixed priority, lowest index wins (ALU>BJP>LSU>QIU); no pointer.
// TESTING
//  1 Reset, ALU add op1=5 op2=7 tag=3 -> next cycle rsp_valid=1 src=0 tag=3 res=12.
//  2 BJP lt op1=2 op2=9, rsp_ready=1 -> rsp_cmp=1 rsp_res=0 src=1; eq 4,4 -> rsp_cmp=1.
//  3 rsp_ready=0 after one response, LSU valid -> req_ready=0 and rsp_* held
//    for 5 cycles; then rsp_ready=1 -> LSU accepted same cycle, rsp next cycle.
//  4 All 4 valid continuously, rsp_ready=1: RR_EN grant order 0,1,2,3,0;
//    without macro 0,0,0,0.
//  5 ALU alu_opsel=4'b0110 accepted -> err_sticky=1 and stays 1 through later
//    legal ops until rst_n=0.
//  6 rst_n=0 while FULL -> next cycle rsp_valid=0, err_sticky=0, grant order restarts at 0.

Source files
------------

// File: rtl/qpu_exu_alu_arb_if.sv
// ============================================================================
// Module : qpu_exu_alu_arb_if
// Brief  : Request, datapath and response bundle for the EXU ALU arbiter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface qpu_exu_alu_arb_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 4
);
    logic [3:0]          req_valid;
    logic [3:0]          req_ready;
    logic [4*XLEN-1:0]   req_op1;
    logic [4*XLEN-1:0]   req_op2;
    logic [4*TAG_W-1:0]  req_tag;
    logic [3:0]          alu_opsel;
    logic [3:0]          bjp_cmpsel;

    logic [3:0]          dp_req;
    logic [XLEN-1:0]     dp_op1;
    logic [XLEN-1:0]     dp_op2;
    logic [3:0]          dp_alu_op;
    logic [3:0]          dp_bjp_cmp;
    logic [XLEN-1:0]     dp_res;
    logic                dp_cmp_res;

    logic                rsp_valid;
    logic                rsp_ready;
    logic [1:0]          rsp_src;
    logic [TAG_W-1:0]    rsp_tag;
    logic [XLEN-1:0]     rsp_res;
    logic                rsp_cmp;
    logic                err_sticky;

    modport slave (
        input  req_valid, req_op1, req_op2, req_tag, alu_opsel, bjp_cmpsel,
        input  dp_res, dp_cmp_res, rsp_ready,
        output req_ready, dp_req, dp_op1, dp_op2, dp_alu_op, dp_bjp_cmp,
        output rsp_valid, rsp_src, rsp_tag, rsp_res, rsp_cmp, err_sticky
    );

    modport master (
        output req_valid, req_op1, req_op2, req_tag, alu_opsel, bjp_cmpsel,
        output dp_res, dp_cmp_res, rsp_ready,
        input  req_ready, dp_req, dp_op1, dp_op2, dp_alu_op, dp_bjp_cmp,
        input  rsp_valid, rsp_src, rsp_tag, rsp_res, rsp_cmp, err_sticky
    );
endinterface

`default_nettype wire

// File: rtl/qpu_exu_alu_arb.sv
// ============================================================================
// Module : qpu_exu_alu_arb
// Brief  : Grants one of ALU/BJP/LSU/QIU per cycle onto the shared ALU
//          datapath and registers its result in a one-entry response slot.
//          QPU_ALU_ARB_RR_EN selects round-robin, otherwise fixed priority.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module qpu_exu_alu_arb #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 4
) (
    input  wire logic            clk,
    input  wire logic            rst_n,
    qpu_exu_alu_arb_if.slave     bus
);

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    localparam logic [1:0] c_SRC_BJP = 2'd1;

    state_t              r_state;
    logic                r_rsp_valid;
    logic [1:0]          r_rsp_src;
    logic [TAG_W-1:0]    r_rsp_tag;
    logic [XLEN-1:0]     r_rsp_res;
    logic                r_rsp_cmp;
    logic                r_err_sticky;
`ifdef QPU_ALU_ARB_RR_EN
    logic [1:0]          r_ptr;
`endif

    logic [XLEN-1:0]     w_op1 [4];
    logic [XLEN-1:0]     w_op2 [4];
    logic [TAG_W-1:0]    w_tag [4];

    logic                w_can_accept;
    logic                w_any;
    logic                w_accept;
    logic [1:0]          w_gidx;
    logic [3:0]          w_grant;
    logic                w_bad_op;

    function automatic logic f_onehot4(input logic [3:0] v);
        return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
    endfunction

    generate
        for (genvar i = 0; i < 4; i++) begin : g_src
            assign w_op1[i] = bus.req_op1[i*XLEN  +: XLEN];
            assign w_op2[i] = bus.req_op2[i*XLEN  +: XLEN];
            assign w_tag[i] = bus.req_tag[i*TAG_W +: TAG_W];
        end
    endgenerate

    // The slot can take a new result if it is empty or is being drained now.
    assign w_can_accept = (r_state == ST_EMPTY) || bus.rsp_ready;

    always_comb begin
        w_any  = 1'b0;
        w_gidx = 2'd0;
`ifdef QPU_ALU_ARB_RR_EN
        for (int k = 1; k <= 4; k++) begin
            logic [1:0] v_idx;
            v_idx = r_ptr + 2'(k);
            if (!w_any && bus.req_valid[v_idx]) begin
                w_any  = 1'b1;
                w_gidx = v_idx;
            end
        end
`else
        for (int k = 0; k < 4; k++) begin
            if (!w_any && bus.req_valid[k]) begin
                w_any  = 1'b1;
                w_gidx = 2'(k);
            end
        end
`endif
    end

    assign w_accept = w_can_accept && w_any;
    assign w_grant  = w_accept ? (4'd1 << w_gidx) : 4'd0;

    assign w_bad_op = (w_grant[0] && !f_onehot4(bus.alu_opsel)) ||
                      (w_grant[1] && !f_onehot4(bus.bjp_cmpsel));

    assign bus.req_ready  = w_grant;
    assign bus.dp_req     = w_grant;
    assign bus.dp_op1     = w_accept   ? w_op1[w_gidx]  : '0;
    assign bus.dp_op2     = w_accept   ? w_op2[w_gidx]  : '0;
    assign bus.dp_alu_op  = w_grant[0] ? bus.alu_opsel  : 4'd0;
    assign bus.dp_bjp_cmp = w_grant[1] ? bus.bjp_cmpsel : 4'd0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= ST_EMPTY;
            r_rsp_valid  <= 1'b0;
            r_rsp_src    <= 2'd0;
            r_rsp_tag    <= '0;
            r_rsp_res    <= '0;
            r_rsp_cmp    <= 1'b0;
            r_err_sticky <= 1'b0;
`ifdef QPU_ALU_ARB_RR_EN
            r_ptr        <= 2'd3;
`endif
        end else begin
            // The datapath is combinational, so its result is valid at the accept edge.
            if (w_accept) begin
                r_state      <= ST_FULL;
                r_rsp_valid  <= 1'b1;
                r_rsp_src    <= w_gidx;
                r_rsp_tag    <= w_tag[w_gidx];
                r_rsp_res    <= (w_gidx == c_SRC_BJP) ? '0 : bus.dp_res;
                r_rsp_cmp    <= (w_gidx == c_SRC_BJP) ? bus.dp_cmp_res : 1'b0;
                r_err_sticky <= r_err_sticky | w_bad_op;
`ifdef QPU_ALU_ARB_RR_EN
                r_ptr        <= w_gidx;
`endif
            end else begin
                case (r_state)
                    ST_FULL: begin
                        if (bus.rsp_ready) begin
                            r_state     <= ST_EMPTY;
                            r_rsp_valid <= 1'b0;
                        end
                    end
                    default: begin
                        r_state     <= ST_EMPTY;
                        r_rsp_valid <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.rsp_valid  = r_rsp_valid;
    assign bus.rsp_src    = r_rsp_src;
    assign bus.rsp_tag    = r_rsp_tag;
    assign bus.rsp_res    = r_rsp_res;
    assign bus.rsp_cmp    = r_rsp_cmp;
    assign bus.err_sticky = r_err_sticky;

endmodule

`default_nettype wire

// File: tb/tb_qpu_exu_alu_arb.sv
// ============================================================================
// Module : tb_qpu_exu_alu_arb
// Brief  : Scoreboard bench for qpu_exu_alu_arb with a behavioural datapath.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_qpu_exu_alu_arb;

    localparam int XLEN  = 32;
    localparam int TAG_W = 4;

    typedef struct {
        logic [1:0]       src;
        logic [TAG_W-1:0] tag;
        logic [XLEN-1:0]  res;
        logic             cmp;
    } rsp_t;

    logic clk;
    logic rst_n;

    qpu_exu_alu_arb_if #(.XLEN(XLEN), .TAG_W(TAG_W)) bus ();

    qpu_exu_alu_arb #(.XLEN(XLEN), .TAG_W(TAG_W)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_cmp;
    int n_err;

    logic [XLEN-1:0]  s_op1 [4];
    logic [XLEN-1:0]  s_op2 [4];
    logic [TAG_W-1:0] s_tag [4];

    rsp_t       sb [$];
    int         glog [$];
    logic       m_full;
    logic [1:0] m_ptr;
    logic       m_err;
    logic [3:0] acc_mask;
    logic       hold;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [XLEN-1:0] f_alu(input logic [3:0] sel, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
        logic [XLEN-1:0] r;
        r = '0;
        if (sel[3]) r = r | (a + b);
        if (sel[2]) r = r | (a | b);
        if (sel[1]) r = r | (a ^ b);
        if (sel[0]) r = r | (a & b);
        return r;
    endfunction

    function automatic logic f_cmp(input logic [3:0] sel, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
        return (sel[3] && (a == b)) || (sel[2] && (a != b)) ||
               (sel[1] && (a <  b)) || (sel[0] && (a >  b));
    endfunction

    function automatic logic [3:0] f_grant(input logic [3:0] v, input logic [1:0] ptr);
`ifdef QPU_ALU_ARB_RR_EN
        for (int k = 1; k <= 4; k++) begin
            logic [1:0] ix;
            ix = ptr + 2'(k);
            if (v[ix]) return 4'd1 << ix;
        end
`else
        for (int k = 0; k < 4; k++)
            if (v[k]) return 4'd1 << k;
`endif
        return 4'd0;
    endfunction

    always_comb begin
        bus.req_op1 = '0;
        bus.req_op2 = '0;
        bus.req_tag = '0;
        for (int i = 0; i < 4; i++) begin
            bus.req_op1[i*XLEN  +: XLEN]  = s_op1[i];
            bus.req_op2[i*XLEN  +: XLEN]  = s_op2[i];
            bus.req_tag[i*TAG_W +: TAG_W] = s_tag[i];
        end
    end

    // Stand-in for the shared ALU datapath.
    always_comb begin
        bus.dp_res     = '0;
        bus.dp_cmp_res = f_cmp(bus.dp_bjp_cmp, bus.dp_op1, bus.dp_op2);
        if (bus.dp_req[0])
            bus.dp_res = f_alu(bus.dp_alu_op, bus.dp_op1, bus.dp_op2);
        else if (!bus.dp_req[1])
            bus.dp_res = bus.dp_op1 + bus.dp_op2;
    end

    always @(negedge clk) begin
        logic [3:0] g;
        int         gi;
        rsp_t       e;
        if (!rst_n) begin
            m_full   = 1'b0;
            m_ptr    = 2'd3;
            m_err    = 1'b0;
            acc_mask = 4'd0;
            sb.delete();
        end else begin
            g  = (!m_full || bus.rsp_ready) ? f_grant(bus.req_valid, m_ptr) : 4'd0;
            gi = 0;
            for (int i = 0; i < 4; i++) if (g[i]) gi = i;

            check_eq("rsp_valid", bus.rsp_valid, m_full);
            if (m_full) begin
                check_eq("sb_nonempty", sb.size() > 0, 1);
                if (sb.size() > 0) begin
                    check_eq("rsp_src", bus.rsp_src, sb[0].src);
                    check_eq("rsp_tag", bus.rsp_tag, sb[0].tag);
                    check_eq("rsp_res", bus.rsp_res, sb[0].res);
                    check_eq("rsp_cmp", bus.rsp_cmp, sb[0].cmp);
                end
            end
            check_eq("req_ready",  bus.req_ready, g);
            check_eq("dp_req",     bus.dp_req, g);
            check_eq("dp_op1",     bus.dp_op1, (g != 0) ? s_op1[gi] : '0);
            check_eq("dp_op2",     bus.dp_op2, (g != 0) ? s_op2[gi] : '0);
            check_eq("dp_alu_op",  bus.dp_alu_op,  g[0] ? bus.alu_opsel  : 4'd0);
            check_eq("dp_bjp_cmp", bus.dp_bjp_cmp, g[1] ? bus.bjp_cmpsel : 4'd0);
            check_eq("err_sticky", bus.err_sticky, m_err);

            if (m_full && bus.rsp_ready) begin
                if (sb.size() > 0) void'(sb.pop_front());
                m_full = 1'b0;
            end
            if (g != 0) begin
                e.src = 2'(gi);
                e.tag = s_tag[gi];
                e.res = (gi == 0) ? f_alu(bus.alu_opsel, s_op1[gi], s_op2[gi]) :
                        (gi == 1) ? '0 : s_op1[gi] + s_op2[gi];
                e.cmp = (gi == 1) ? f_cmp(bus.bjp_cmpsel, s_op1[gi], s_op2[gi]) : 1'b0;
                sb.push_back(e);
                glog.push_back(gi);
                m_full = 1'b1;
                m_ptr  = 2'(gi);
                if (gi == 0 && !$onehot(bus.alu_opsel))  m_err = 1'b1;
                if (gi == 1 && !$onehot(bus.bjp_cmpsel)) m_err = 1'b1;
            end
            acc_mask = g;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (!hold) bus.req_valid = bus.req_valid & ~acc_mask;
    endtask

    task automatic do_reset();
        rst_n         = 1'b0;
        bus.req_valid = 4'd0;
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        int exp_order [5];
`ifdef QPU_ALU_ARB_RR_EN
        exp_order = '{0, 1, 2, 3, 0};
`else
        exp_order = '{0, 0, 0, 0, 0};
`endif
        n_cmp = 0;
        n_err = 0;
        hold  = 1'b0;
        rst_n = 1'b0;
        bus.req_valid  = 4'd0;
        bus.rsp_ready  = 1'b1;
        bus.alu_opsel  = 4'b1000;
        bus.bjp_cmpsel = 4'b1000;
        for (int i = 0; i < 4; i++) begin
            s_op1[i] = '0;
            s_op2[i] = '0;
            s_tag[i] = '0;
        end
        do_reset();

        check_eq("rst_rsp_valid", bus.rsp_valid, 0);
        check_eq("rst_rsp_src",   bus.rsp_src, 0);
        check_eq("rst_rsp_tag",   bus.rsp_tag, 0);
        check_eq("rst_rsp_res",   bus.rsp_res, 0);
        check_eq("rst_rsp_cmp",   bus.rsp_cmp, 0);
        check_eq("rst_err",       bus.err_sticky, 0);

        // ALU add, one-cycle latency
        s_op1[0] = 32'd5; s_op2[0] = 32'd7; s_tag[0] = 4'd3;
        bus.alu_opsel = 4'b1000;
        bus.req_valid = 4'b0001;
        step();
        check_eq("t1_valid", bus.rsp_valid, 1);
        check_eq("t1_src",   bus.rsp_src, 0);
        check_eq("t1_tag",   bus.rsp_tag, 3);
        check_eq("t1_res",   bus.rsp_res, 12);

        // BJP lt then eq, back to back
        s_op1[1] = 32'd2; s_op2[1] = 32'd9; s_tag[1] = 4'd6;
        bus.bjp_cmpsel = 4'b0010;
        bus.req_valid  = 4'b0010;
        step();
        check_eq("t2_lt_cmp", bus.rsp_cmp, 1);
        check_eq("t2_lt_res", bus.rsp_res, 0);
        check_eq("t2_lt_src", bus.rsp_src, 1);
        s_op1[1] = 32'd4; s_op2[1] = 32'd4; s_tag[1] = 4'd9;
        bus.bjp_cmpsel = 4'b1000;
        bus.req_valid  = 4'b0010;
        step();
        check_eq("t2_eq_cmp", bus.rsp_cmp, 1);
        check_eq("t2_eq_tag", bus.rsp_tag, 9);

        // Backpressure holds the response and blocks new grants
        s_op1[0] = 32'h0F; s_op2[0] = 32'hFF; s_tag[0] = 4'd1;
        bus.alu_opsel = 4'b0010;
        bus.req_valid = 4'b0001;
        step();
        bus.rsp_ready = 1'b0;
        s_op1[2] = 32'd10; s_op2[2] = 32'd20; s_tag[2] = 4'd5;
        bus.req_valid = 4'b0100;
        for (int i = 0; i < 5; i++) begin
            step();
            check_eq("t3_hold_ready", bus.req_ready, 0);
            check_eq("t3_hold_src",   bus.rsp_src, 0);
            check_eq("t3_hold_res",   bus.rsp_res, 32'hF0);
        end
        bus.rsp_ready = 1'b1;
        #1;
        check_eq("t3_release_ready", bus.req_ready, 4'b0100);
        step();
        check_eq("t3_lsu_src", bus.rsp_src, 2);
        check_eq("t3_lsu_res", bus.rsp_res, 30);
        check_eq("t3_lsu_tag", bus.rsp_tag, 5);

        // All sources requesting continuously
        do_reset();
        for (int i = 0; i < 4; i++) begin
            s_op1[i] = XLEN'(i + 1);
            s_op2[i] = 32'd100;
            s_tag[i] = TAG_W'(i + 8);
        end
        bus.alu_opsel  = 4'b1000;
        bus.bjp_cmpsel = 4'b0001;
        glog.delete();
        hold = 1'b1;
        bus.req_valid = 4'b1111;
        for (int i = 0; i < 5; i++) step();
        bus.req_valid = 4'd0;
        hold = 1'b0;
        check_eq("t4_count", glog.size(), 5);
        for (int i = 0; i < 5; i++)
            check_eq("t4_order", (i < glog.size()) ? glog[i] : 99, exp_order[i]);
        step();

        // Illegal ALU op sets the sticky error
        s_op1[0] = 32'd3; s_op2[0] = 32'd5; s_tag[0] = 4'd7;
        bus.alu_opsel = 4'b0110;
        bus.req_valid = 4'b0001;
        step();
        check_eq("t5_err_set", bus.err_sticky, 1);
        check_eq("t5_bad_res", bus.rsp_res, 7);
        bus.alu_opsel = 4'b1000;
        bus.req_valid = 4'b0001;
        step();
        check_eq("t5_err_keep1", bus.err_sticky, 1);
        bus.req_valid = 4'b0100;
        step();
        check_eq("t5_err_keep2", bus.err_sticky, 1);

        // Reset while a response is held
        check_eq("t6_full_before", bus.rsp_valid, 1);
        rst_n = 1'b0;
        step();
        check_eq("t6_valid_cleared", bus.rsp_valid, 0);
        check_eq("t6_err_cleared",   bus.err_sticky, 0);
        rst_n = 1'b1;
        step();
        glog.delete();
        hold = 1'b1;
        bus.req_valid = 4'b1111;
        step();
        step();
        bus.req_valid = 4'd0;
        hold = 1'b0;
        check_eq("t6_first_grant",  (glog.size() > 0) ? glog[0] : 99, 0);
        check_eq("t6_second_grant", (glog.size() > 1) ? glog[1] : 99, exp_order[1]);
        step();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
